// File: rtl/rggen_register_bus_initiator.sv
// rggen_register_bus_initiator
// Turns single host commands into register-bus requests, one outstanding at a time.
// Each request is held until the target acks or the ack timeout expires. Exactly
// one response is returned per accepted command.
module rggen_register_bus_initiator #(
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNTER_WIDTH  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic                      i_cmd_write,
    input  logic [ADDRESS_WIDTH-1:0]  i_cmd_address,
    input  logic [DATA_WIDTH-1:0]     i_cmd_write_data,
    input  logic [DATA_WIDTH/8-1:0]   i_cmd_strobe,
    output logic                      o_bus_valid,
    output logic                      o_bus_write,
    output logic [ADDRESS_WIDTH-1:0]  o_bus_address,
    output logic [DATA_WIDTH-1:0]     o_bus_write_data,
    output logic [DATA_WIDTH-1:0]     o_bus_mask,
    input  logic                      i_bus_ready,
    input  logic [1:0]                i_bus_status,
    input  logic [DATA_WIDTH-1:0]     i_bus_read_data,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [1:0]                o_rsp_status,
    output logic                      o_rsp_timeout,
    output logic [DATA_WIDTH-1:0]     o_rsp_read_data
);

    localparam int STROBE_WIDTH = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    // Counter value seen on the last REQUEST cycle before the abort fires.
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        TIMEOUT_EN ? COUNTER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        RESPONSE
    } state_e;

    state_e                      state_q, state_d;
    logic                        write_q, write_d;
    logic [ADDRESS_WIDTH-1:0]    address_q, address_d;
    logic [DATA_WIDTH-1:0]       write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0]       mask_q, mask_d;
    logic [COUNTER_WIDTH-1:0]    count_q, count_d;
    logic [1:0]                  rsp_status_q, rsp_status_d;
    logic                        rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0]       rsp_read_data_q, rsp_read_data_d;

    // Each byte strobe becomes eight identical mask bits.
    function automatic logic [DATA_WIDTH-1:0] expand_strobe(
        input logic [STROBE_WIDTH-1:0] strobe
    );
        logic [DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < STROBE_WIDTH; i++) begin
            mask[8*i +: 8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

    // State register; reset drops bus/response valid immediately and abandons the transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request payload, timeout counter and response payload registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            write_q         <= 1'b0;
            address_q       <= '0;
            write_data_q    <= '0;
            mask_q          <= '0;
            count_q         <= '0;
            rsp_status_q    <= 2'b00;
            rsp_timeout_q   <= 1'b0;
            rsp_read_data_q <= '0;
        end else begin
            write_q         <= write_d;
            address_q       <= address_d;
            write_data_q    <= write_data_d;
            mask_q          <= mask_d;
            count_q         <= count_d;
            rsp_status_q    <= rsp_status_d;
            rsp_timeout_q   <= rsp_timeout_d;
            rsp_read_data_q <= rsp_read_data_d;
        end
    end

    // Next-state and payload capture; i_bus_ready only matters while in REQUEST.
    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        address_d       = address_q;
        write_data_d    = write_data_q;
        mask_d          = mask_q;
        count_d         = count_q;
        rsp_status_d    = rsp_status_q;
        rsp_timeout_d   = rsp_timeout_q;
        rsp_read_data_d = rsp_read_data_q;

        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    write_d      = i_cmd_write;
                    address_d    = i_cmd_address;
                    write_data_d = i_cmd_write_data;
                    mask_d       = expand_strobe(i_cmd_strobe);
                    count_d      = '0;
                    state_d      = REQUEST;
                end
            end
            REQUEST: begin
                if (i_bus_ready) begin
                    // A late ack on the abort cycle still counts as a normal completion.
                    rsp_status_d    = i_bus_status;
                    rsp_timeout_d   = 1'b0;
                    rsp_read_data_d = write_q ? '0 : (i_bus_read_data & mask_q);
                    state_d         = RESPONSE;
                end else if (TIMEOUT_EN && (count_q == TIMEOUT_LAST)) begin
                    rsp_status_d    = STATUS_TIMEOUT;
                    rsp_timeout_d   = 1'b1;
                    rsp_read_data_d = '0;
                    state_d         = RESPONSE;
                end else if (count_q != '1) begin
                    count_d = count_q + COUNTER_WIDTH'(1);
                end
            end
            RESPONSE: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_cmd_ready      = (state_q == IDLE);
    assign o_bus_valid      = (state_q == REQUEST);
    assign o_bus_write      = write_q;
    assign o_bus_address    = address_q;
    assign o_bus_write_data = write_data_q;
    assign o_bus_mask       = mask_q;
    assign o_rsp_valid      = (state_q == RESPONSE);
    assign o_rsp_status     = rsp_status_q;
    assign o_rsp_timeout    = rsp_timeout_q;
    assign o_rsp_read_data  = rsp_read_data_q;

endmodule

// File: tb/tb_rggen_register_bus_initiator.sv
// Testbench for rggen_register_bus_initiator: directed cases plus random commands,
// with a bus target model, a response scoreboard and a monitor.
module tb_rggen_register_bus_initiator;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic            i_cmd_write;
    logic [AW-1:0]   i_cmd_address;
    logic [DW-1:0]   i_cmd_write_data;
    logic [SW-1:0]   i_cmd_strobe;
    logic            o_bus_valid;
    logic            o_bus_write;
    logic [AW-1:0]   o_bus_address;
    logic [DW-1:0]   o_bus_write_data;
    logic [DW-1:0]   o_bus_mask;
    logic            i_bus_ready;
    logic [1:0]      i_bus_status;
    logic [DW-1:0]   i_bus_read_data;
    logic            o_rsp_valid;
    logic            i_rsp_ready = 1'b0;
    logic [1:0]      o_rsp_status;
    logic            o_rsp_timeout;
    logic [DW-1:0]   o_rsp_read_data;

    always #5 i_clk = ~i_clk;

    rggen_register_bus_initiator #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO),
        .COUNTER_WIDTH  (8)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_write      (i_cmd_write),
        .i_cmd_address    (i_cmd_address),
        .i_cmd_write_data (i_cmd_write_data),
        .i_cmd_strobe     (i_cmd_strobe),
        .o_bus_valid      (o_bus_valid),
        .o_bus_write      (o_bus_write),
        .o_bus_address    (o_bus_address),
        .o_bus_write_data (o_bus_write_data),
        .o_bus_mask       (o_bus_mask),
        .i_bus_ready      (i_bus_ready),
        .i_bus_status     (i_bus_status),
        .i_bus_read_data  (i_bus_read_data),
        .o_rsp_valid      (o_rsp_valid),
        .i_rsp_ready      (i_rsp_ready),
        .o_rsp_status     (o_rsp_status),
        .o_rsp_timeout    (o_rsp_timeout),
        .o_rsp_read_data  (o_rsp_read_data)
    );

    // What the target should see and how it answers (delay = 0-based REQUEST cycle of the ack).
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
        int            delay;
        logic [1:0]    status;
        logic [DW-1:0] rdata;
        bit            abort;
    } plan_t;

    typedef struct {
        logic [1:0]    status;
        logic          tmo;
        logic [DW-1:0] rdata;
        int            hs_cyc;
        int            lat;
    } rsp_exp_t;

    plan_t    plan_q[$];
    rsp_exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int force_hold  = -1;
    int last_rsp_hs = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] strobe_mask(input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < SW; i++) r[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    // An ack on REQUEST cycle d (d < TMO) completes normally; otherwise the abort fires
    // after TMO cycles. Latency counts clock edges from the command handshake edge.
    function automatic rsp_exp_t model(input plan_t p, input int hs);
        rsp_exp_t e;
        e.hs_cyc = hs;
        if (p.delay < TMO) begin
            e.status = p.status;
            e.tmo    = 1'b0;
            e.rdata  = p.wr ? '0 : (p.rdata & p.mask);
            e.lat    = p.delay + 1;
        end else begin
            e.status = 2'b11;
            e.tmo    = 1'b1;
            e.rdata  = '0;
            e.lat    = TMO;
        end
        return e;
    endfunction

    // Bus target: acks according to the plan and checks request stability and duration.
    initial begin : target
        plan_t p;
        int    n;
        int    want;
        i_bus_ready     = 1'b0;
        i_bus_status    = 2'b00;
        i_bus_read_data = '0;
        forever begin
            @(negedge i_clk);
            if (!o_bus_valid) begin
                i_bus_ready     = 1'($urandom);
                i_bus_status    = 2'($urandom);
                i_bus_read_data = $urandom;
            end else if (plan_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL bus_unplanned: o_bus_valid=1 with no command outstanding, required 0");
                i_bus_ready = 1'b1;
            end else begin
                p = plan_q.pop_front();
                n = 0;
                while (o_bus_valid && n < 64) begin
                    check("bus_req", {o_bus_write, o_bus_address, o_bus_write_data, o_bus_mask},
                          {p.wr, p.addr, p.wdata, p.mask});
                    if (n == p.delay) begin
                        i_bus_ready     = 1'b1;
                        i_bus_status    = p.status;
                        i_bus_read_data = p.rdata;
                    end else begin
                        i_bus_ready     = 1'b0;
                        i_bus_status    = 2'($urandom);
                        i_bus_read_data = $urandom;
                    end
                    n++;
                    @(negedge i_clk);
                end
                i_bus_ready = 1'b0;
                if (!p.abort) begin
                    want = (p.delay < TMO) ? p.delay + 1 : TMO;
                    check("bus_cycles", n, want);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each response handshake.
    rsp_exp_t mon_e;
    bit       mon_active = 1'b0;
    int       mon_wait   = 0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            mon_active  = 1'b0;
            i_rsp_ready = 1'b0;
        end else if (o_rsp_valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rsp_unexpected: o_rsp_valid=1 with no response expected, required 0");
                i_rsp_ready = 1'b1;
            end else begin
                mon_e = exp_q[0];
                if (!mon_active) begin
                    mon_active = 1'b1;
                    mon_wait   = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
                    check("rsp_latency", cyc - mon_e.hs_cyc, mon_e.lat);
                end
                check("rsp_payload", {o_rsp_status, o_rsp_timeout, o_rsp_read_data},
                      {mon_e.status, mon_e.tmo, mon_e.rdata});
                check("rsp_cmd_bus_idle", {o_cmd_ready, o_bus_valid}, 2'b00);
                if (mon_wait == 0) begin
                    i_rsp_ready = 1'b1;
                    void'(exp_q.pop_front());
                    mon_active  = 1'b0;
                    last_rsp_hs = cyc + 1;
                end else begin
                    i_rsp_ready = 1'b0;
                    mon_wait--;
                end
            end
        end else begin
            i_rsp_ready = 1'($urandom);
        end
    end

    // Must be called just after a negedge; returns just after the negedge following the handshake.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] strb, input int delay, input logic [1:0] st,
                            input logic [DW-1:0] rd, input bit abort, input bit keep,
                            output int hs);
        plan_t p;
        int    w;
        p.wr     = wr;
        p.addr   = addr;
        p.wdata  = wdata;
        p.mask   = strobe_mask(strb);
        p.delay  = delay;
        p.status = st;
        p.rdata  = rd;
        p.abort  = abort;
        i_cmd_valid      = 1'b1;
        i_cmd_write      = wr;
        i_cmd_address    = addr;
        i_cmd_write_data = wdata;
        i_cmd_strobe     = strb;
        w  = 0;
        hs = -1;
        while (!o_cmd_ready && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        if (!o_cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_accept: o_cmd_ready stayed 0 for %0d cycles, required 1", w);
            i_cmd_valid = 1'b0;
        end else begin
            hs = cyc + 1;
            plan_q.push_back(p);
            if (!abort) exp_q.push_back(model(p, hs));
            @(negedge i_clk);
            if (!keep) begin
                i_cmd_valid      = 1'b0;
                i_cmd_write_data = $urandom;
                i_cmd_strobe     = SW'($urandom);
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || o_rsp_valid || o_bus_valid) && w < 300) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d responses still outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin : main
        int hs_a, hs_b;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rd;
        logic [SW-1:0] strb;
        logic [1:0]    st;
        int            d;
        bit            keep;

        i_rst_n          = 1'b0;
        i_cmd_valid      = 1'b0;
        i_cmd_write      = 1'b0;
        i_cmd_address    = '0;
        i_cmd_write_data = '0;
        i_cmd_strobe     = '0;
        repeat (3) @(negedge i_clk);
        check("reset_ctrl", {o_cmd_ready, o_bus_valid, o_rsp_valid}, 3'b100);
        check("reset_bus", {o_bus_write, o_bus_address, o_bus_write_data, o_bus_mask}, '0);
        check("reset_rsp", {o_rsp_status, o_rsp_timeout, o_rsp_read_data}, '0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Write with full strobe, ack on the third REQUEST cycle.
        send_cmd(1'b1, 8'h10, 32'hA5A5_0F0F, 4'hF, 2, 2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, hs_a);
        drain();
        // Read with lower-half strobe, ack immediately.
        send_cmd(1'b0, 8'h04, 32'h0, 4'h3, 0, 2'b00, 32'h1234_5678, 1'b0, 1'b0, hs_a);
        drain();
        // No ack at all: abort after TMO cycles.
        send_cmd(1'b0, 8'h20, 32'h0, 4'hF, 100, 2'b00, 32'hFFFF_FFFF, 1'b0, 1'b0, hs_a);
        drain();
        // Ack on the abort cycle wins, with SLVERR.
        send_cmd(1'b1, 8'h24, 32'h0BAD_F00D, 4'hF, TMO - 1, 2'b10, 32'h0, 1'b0, 1'b0, hs_a);
        drain();
        // Zero strobe still reaches the bus, read and write.
        send_cmd(1'b0, 8'h30, 32'h0, 4'h0, 1, 2'b01, 32'hCAFE_BABE, 1'b0, 1'b0, hs_a);
        send_cmd(1'b1, 8'h34, 32'h5555_AAAA, 4'h0, 0, 2'b11, 32'h0, 1'b0, 1'b0, hs_a);
        drain();

        // Response held for 5 cycles while the next command waits with valid high.
        force_hold = 5;
        send_cmd(1'b0, 8'h40, 32'h0, 4'hC, 1, 2'b00, 32'h89AB_CDEF, 1'b0, 1'b1, hs_a);
        send_cmd(1'b1, 8'h44, 32'h1357_9BDF, 4'h5, 0, 2'b00, 32'h0, 1'b0, 1'b0, hs_b);
        check("next_cmd_after_rsp_hs", hs_b - last_rsp_hs, 1);
        drain();
        force_hold = -1;

        // Random traffic, mixed back-to-back and gapped commands.
        for (int i = 0; i < 60; i++) begin
            wr    = 1'($urandom);
            addr  = AW'($urandom);
            wdata = $urandom;
            strb  = SW'($urandom);
            d     = int'($urandom_range(0, 6));
            st    = 2'($urandom);
            rd    = $urandom;
            keep  = 1'($urandom);
            send_cmd(wr, addr, wdata, strb, d, st, rd, 1'b0, keep, hs_a);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        i_cmd_valid = 1'b0;
        drain();
        @(negedge i_clk);

        // Asynchronous reset in the middle of a request: transaction is dropped silently.
        send_cmd(1'b0, 8'h50, 32'h0, 4'hF, 100, 2'b00, 32'h0, 1'b1, 1'b0, hs_a);
        @(posedge i_clk);
        check("rst_pre_bus_valid", o_bus_valid, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_async_drop", {o_cmd_ready, o_bus_valid, o_rsp_valid}, 3'b100);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            check("rst_after_idle", {o_cmd_ready, o_bus_valid, o_rsp_valid}, 3'b100);
        end

        // Normal operation resumes after reset.
        send_cmd(1'b0, 8'h60, 32'h0, 4'h9, 1, 2'b01, 32'h7654_3210, 1'b0, 1'b0, hs_a);
        drain();
        repeat (2) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
